// File: rtl/lsu_dtcm_arb_pkg.sv
// Shared defines for the LSU DTCM arbiter: widths, access-size encodings,
// the default response depth, and the load-result extension helper.
package lsu_dtcm_arb_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned DTCM_ADDR_WIDTH   = 16;
  localparam int unsigned ITAG_WIDTH        = 4;
  localparam int unsigned RSP_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;

  typedef enum logic {
    SrcAgu = 1'b0,
    SrcExt = 1'b1
  } src_e;

  typedef struct packed {
    src_e                  src;
    logic                  read;
    size_e                 size;
    logic                  usign;
    logic [1:0]            off;
    logic [ITAG_WIDTH-1:0] itag;
  } inflight_t;

  typedef struct packed {
    src_e                  src;
    logic [ITAG_WIDTH-1:0] itag;
    logic [XLEN-1:0]       data;
  } rsp_t;

  // Select the addressed byte/half of the RAM word and extend it to XLEN.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] dout,
                                                  input size_e           size,
                                                  input logic [1:0]      off,
                                                  input logic            usign);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    b = dout[{off, 3'b000} +: 8];
    h = dout[{off[1], 4'b0000} +: 16];
    unique case (size)
      SizeByte: res = {{(XLEN-8){b[7] & ~usign}}, b};
      SizeHalf: res = {{(XLEN-16){h[15] & ~usign}}, h};
      default:  res = dout;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_dtcm_arb_if.sv
// Requester command/response handshakes and the DTCM port of the arbiter.
interface lsu_dtcm_arb_if;
  import lsu_dtcm_arb_pkg::*;

  logic                         agu_cmd_valid;
  logic                         agu_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr;
  logic                         agu_cmd_read;
  logic [XLEN-1:0]              agu_cmd_wdata;
  logic [XLEN/8-1:0]            agu_cmd_wmask;
  logic [1:0]                   agu_cmd_size;
  logic                         agu_cmd_usign;
  logic [ITAG_WIDTH-1:0]        agu_cmd_itag;

  logic                         ext_cmd_valid;
  logic                         ext_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0]   ext_cmd_addr;
  logic                         ext_cmd_read;
  logic [XLEN-1:0]              ext_cmd_wdata;
  logic [XLEN/8-1:0]            ext_cmd_wmask;
  logic [1:0]                   ext_cmd_size;
  logic                         ext_cmd_usign;

  logic                         agu_rsp_valid;
  logic                         agu_rsp_ready;
  logic [XLEN-1:0]              agu_rsp_rdata;
  logic [ITAG_WIDTH-1:0]        agu_rsp_itag;

  logic                         ext_rsp_valid;
  logic                         ext_rsp_ready;
  logic [XLEN-1:0]              ext_rsp_rdata;

  logic                         ram_cs;
  logic                         ram_we;
  logic [DTCM_ADDR_WIDTH-3:0]   ram_addr;
  logic [XLEN/8-1:0]            ram_wem;
  logic [XLEN-1:0]              ram_din;
  logic [XLEN-1:0]              ram_dout;

  modport slave (
    input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata, agu_cmd_wmask,
           agu_cmd_size, agu_cmd_usign, agu_cmd_itag,
    output agu_cmd_ready,
    input  ext_cmd_valid, ext_cmd_addr, ext_cmd_read, ext_cmd_wdata, ext_cmd_wmask,
           ext_cmd_size, ext_cmd_usign,
    output ext_cmd_ready,
    output agu_rsp_valid, agu_rsp_rdata, agu_rsp_itag,
    input  agu_rsp_ready,
    output ext_rsp_valid, ext_rsp_rdata,
    input  ext_rsp_ready,
    output ram_cs, ram_we, ram_addr, ram_wem, ram_din,
    input  ram_dout
  );

  modport master (
    output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata, agu_cmd_wmask,
           agu_cmd_size, agu_cmd_usign, agu_cmd_itag,
    input  agu_cmd_ready,
    output ext_cmd_valid, ext_cmd_addr, ext_cmd_read, ext_cmd_wdata, ext_cmd_wmask,
           ext_cmd_size, ext_cmd_usign,
    input  ext_cmd_ready,
    input  agu_rsp_valid, agu_rsp_rdata, agu_rsp_itag,
    output agu_rsp_ready,
    input  ext_rsp_valid, ext_rsp_rdata,
    output ext_rsp_ready,
    input  ram_cs, ram_we, ram_addr, ram_wem, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/lsu_rsp_fifo.sv
// Ordered response FIFO; pointers wrap modulo Depth, storage is not reset.
module lsu_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    if (pop_i)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/lsu_dtcm_arb.sv
// Round-robin arbiter between the AGU and an external requester for a
// single-port DTCM, returning extended load data through an ordered FIFO.
module lsu_dtcm_arb
  import lsu_dtcm_arb_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  lsu_dtcm_arb_if.slave bus
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  src_e               rr_q, rr_d;
  logic               infl_vld_q;
  inflight_t          infl_q, infl_d;
  rsp_t               head, push_data;
  logic               fifo_empty;
  logic [CntW-1:0]    fifo_cnt;
  logic [CntW:0]      occ, limit;
  logic               head_vld, pop, can_issue, gnt_agu, gnt_ext, gnt;
  logic [DTCM_ADDR_WIDTH-1:0] win_addr;

  // A response popped this cycle frees its slot in time for a new grant.
  assign occ   = {1'b0, fifo_cnt} + (CntW+1)'(infl_vld_q);
  assign limit = (CntW+1)'(RSP_DEPTH) + (CntW+1)'(pop);

  always_comb begin
    head_vld  = ~fifo_empty & ~rst;
    pop       = head_vld & ((head.src == SrcAgu) ? bus.agu_rsp_ready : bus.ext_rsp_ready);
    can_issue = ~rst & (occ < limit);
    gnt_agu   = 1'b0;
    gnt_ext   = 1'b0;
    if (can_issue) begin
      if (bus.agu_cmd_valid && bus.ext_cmd_valid) begin
        if (rr_q == SrcExt) gnt_agu = 1'b1;
        else                gnt_ext = 1'b1;
      end else begin
        gnt_agu = bus.agu_cmd_valid;
        gnt_ext = bus.ext_cmd_valid;
      end
    end
    gnt  = gnt_agu | gnt_ext;
    rr_d = rr_q;
    if (gnt_ext)      rr_d = SrcExt;
    else if (gnt_agu) rr_d = SrcAgu;
  end

  always_comb begin
    infl_d = '0;
    if (gnt_ext) begin
      win_addr     = bus.ext_cmd_addr;
      infl_d.src   = SrcExt;
      infl_d.read  = bus.ext_cmd_read;
      infl_d.size  = size_e'(bus.ext_cmd_size);
      infl_d.usign = bus.ext_cmd_usign;
      bus.ram_wem  = bus.ext_cmd_wmask;
      bus.ram_din  = bus.ext_cmd_wdata;
    end else begin
      win_addr     = bus.agu_cmd_addr;
      infl_d.src   = SrcAgu;
      infl_d.read  = bus.agu_cmd_read;
      infl_d.size  = size_e'(bus.agu_cmd_size);
      infl_d.usign = bus.agu_cmd_usign;
      infl_d.itag  = bus.agu_cmd_itag;
      bus.ram_wem  = gnt ? bus.agu_cmd_wmask : '0;
      bus.ram_din  = bus.agu_cmd_wdata;
    end
    infl_d.off        = win_addr[1:0];
    bus.ram_cs        = gnt;
    bus.ram_we        = gnt & ~infl_d.read;
    bus.ram_addr      = win_addr[DTCM_ADDR_WIDTH-1:2];
    bus.agu_cmd_ready = gnt_agu;
    bus.ext_cmd_ready = gnt_ext;
  end

  always_comb begin
    push_data.src  = infl_q.src;
    push_data.itag = infl_q.itag;
    push_data.data = infl_q.read ?
                     load_extend(bus.ram_dout, infl_q.size, infl_q.off, infl_q.usign) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= SrcExt;
      infl_vld_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      infl_vld_q <= gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) infl_q <= infl_d;
  end

  lsu_rsp_fifo #(
    .Width($bits(rsp_t)),
    .Depth(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (infl_vld_q),
    .wdata_i(push_data),
    .pop_i  (pop),
    .rdata_o(head),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  always_comb begin
    bus.agu_rsp_valid = head_vld & (head.src == SrcAgu);
    bus.ext_rsp_valid = head_vld & (head.src == SrcExt);
    bus.agu_rsp_rdata = head.data;
    bus.agu_rsp_itag  = head.itag;
    bus.ext_rsp_rdata = head.data;
  end

endmodule

// File: tb/tb_lsu_dtcm_arb.sv
// Scoreboard bench for lsu_dtcm_arb: a transaction-level model predicts grants
// and responses; a separate monitor checks responses as the DUT presents them.
module tb_lsu_dtcm_arb;
  import lsu_dtcm_arb_pkg::*;

  localparam int unsigned Depth = 2;

  typedef struct {
    logic [15:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic        usign;
    logic [3:0]  itag;
  } cmd_t;

  typedef struct {
    bit          src;
    logic [3:0]  itag;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   last_ext = 1'b1;

  cmd_t        agu_q[$];
  cmd_t        ext_q[$];
  exp_t        exp_q[$];
  logic [31:0] shadow [16];
  logic [31:0] ram [16];

  lsu_dtcm_arb_if bus ();

  lsu_dtcm_arb #(.RSP_DEPTH(Depth)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic usign);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!usign && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (word >> (16 * off[1])) & 32'hFFFF;
      if (!usign && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic cmd_t mk(input logic [15:0] addr, input logic read, input logic [31:0] wd,
                              input logic [1:0] size, input logic usign, input logic [3:0] itag);
    cmd_t c;
    c.addr = addr; c.read = read; c.wdata = wd; c.size = size; c.usign = usign; c.itag = itag;
    c.wmask = (size == 2'd0) ? (4'b0001 << addr[1:0]) :
              (size == 2'd1) ? (4'b0011 << {addr[1], 1'b0}) : 4'b1111;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [1:0]  size;
    logic [15:0] addr;
    size = 2'($urandom_range(0, 2));
    addr = 16'($urandom);
    if (size == 2'd1) addr[0] = 1'b0;
    if (size == 2'd2) addr[1:0] = 2'b00;
    return mk(addr, 1'($urandom), $urandom, size, 1'($urandom), 4'($urandom));
  endfunction

  // DTCM model: read-first, data valid one cycle after chip select.
  initial forever begin
    @(posedge clk);
    if (bus.ram_cs) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we && bus.ram_wem[b]) ram[bus.ram_addr[3:0]][8*b +: 8] <= bus.ram_din[8*b +: 8];
      bus.ram_dout <= ram[bus.ram_addr[3:0]];
    end
  end

  // Command driver: presents the front of each requester queue.
  initial begin
    bus.agu_cmd_valid = 1'b0;
    bus.ext_cmd_valid = 1'b0;
    forever begin
      cmd_t a, e;
      bus.agu_cmd_valid = (agu_q.size() > 0);
      bus.ext_cmd_valid = (ext_q.size() > 0);
      a = (agu_q.size() > 0) ? agu_q[0] : mk(16'h0, 1'b1, 32'h0, 2'd2, 1'b0, 4'h0);
      e = (ext_q.size() > 0) ? ext_q[0] : mk(16'h0, 1'b1, 32'h0, 2'd2, 1'b0, 4'h0);
      bus.agu_cmd_addr  = a.addr;  bus.agu_cmd_read  = a.read;  bus.agu_cmd_wdata = a.wdata;
      bus.agu_cmd_wmask = a.wmask; bus.agu_cmd_size  = a.size;  bus.agu_cmd_usign = a.usign;
      bus.agu_cmd_itag  = a.itag;
      bus.ext_cmd_addr  = e.addr;  bus.ext_cmd_read  = e.read;  bus.ext_cmd_wdata = e.wdata;
      bus.ext_cmd_wmask = e.wmask; bus.ext_cmd_size  = e.size;  bus.ext_cmd_usign = e.usign;
      @(posedge clk);
      #2;
    end
  end

  // Response monitor: the head of the expected queue is visible two cycles after issue.
  initial forever begin
    bit ea, ee;
    @(negedge clk);
    if (rst) begin
      chk("rst_agu_rsp_valid", 64'(bus.agu_rsp_valid), 64'd0);
      chk("rst_ext_rsp_valid", 64'(bus.ext_rsp_valid), 64'd0);
    end else begin
      ea = exp_q.size() > 0 && exp_q[0].src == 1'b0 && cyc >= exp_q[0].cyc + 2;
      ee = exp_q.size() > 0 && exp_q[0].src == 1'b1 && cyc >= exp_q[0].cyc + 2;
      chk("agu_rsp_valid", 64'(bus.agu_rsp_valid), 64'(ea));
      chk("ext_rsp_valid", 64'(bus.ext_rsp_valid), 64'(ee));
      if (ea && bus.agu_rsp_valid && bus.agu_rsp_ready) begin
        chk("agu_rsp", {28'd0, bus.agu_rsp_itag, bus.agu_rsp_rdata},
            {28'd0, exp_q[0].itag, exp_q[0].data});
        void'(exp_q.pop_front());
      end else if (ee && bus.ext_rsp_valid && bus.ext_rsp_ready) begin
        chk("ext_rsp", 64'(bus.ext_rsp_rdata), 64'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
    end
  end

  // Issue model: round-robin grant with a bound on outstanding responses.
  initial forever begin
    bit   av, ev, ga, ge;
    cmd_t c;
    exp_t x;
    @(negedge clk);
    #1;
    if (rst) begin
      chk("rst_outputs", {60'd0, bus.agu_cmd_ready, bus.ext_cmd_ready, bus.ram_cs, bus.ram_we},
          64'd0);
      exp_q.delete();
      last_ext = 1'b1;
    end else begin
      av = agu_q.size() > 0;
      ev = ext_q.size() > 0;
      ga = exp_q.size() < Depth && av && (!ev || last_ext);
      ge = exp_q.size() < Depth && ev && (!av || !last_ext);
      chk("grant", {61'd0, bus.agu_cmd_ready, bus.ext_cmd_ready, bus.ram_cs}, {61'd0, ga, ge, ga | ge});
      if (ga || ge) begin
        c = ga ? agu_q.pop_front() : ext_q.pop_front();
        if (c.read) chk("ram_load", {49'd0, bus.ram_we, bus.ram_addr}, {49'd0, 1'b0, c.addr[15:2]});
        else chk("ram_store", {13'd0, bus.ram_we, bus.ram_addr, bus.ram_wem, bus.ram_din},
                 {13'd0, 1'b1, c.addr[15:2], c.wmask, c.wdata});
        x.src  = ge;
        x.itag = ga ? c.itag : 4'h0;
        x.data = c.read ? ref_load(shadow[c.addr[5:2]], c.addr[1:0], c.size, c.usign) : 32'h0;
        x.cyc  = cyc;
        exp_q.push_back(x);
        if (!c.read)
          for (int b = 0; b < 4; b++)
            if (c.wmask[b]) shadow[c.addr[5:2]][8*b +: 8] = c.wdata[8*b +: 8];
        last_ext = ge;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((agu_q.size() > 0 || ext_q.size() > 0 || exp_q.size() > 0) && n < max) begin
      tick(1);
      n++;
    end
    if (n >= max) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: still outstanding after %0d cycles", max);
    end
    tick(2);
  endtask

  initial begin
    bus.agu_rsp_ready = 1'b1;
    bus.ext_rsp_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    // Fill the modelled words with known data.
    for (int i = 0; i < 16; i++) agu_q.push_back(mk(16'(i * 4), 1'b0, $urandom, 2'd2, 1'b0, 4'h0));
    wait_idle(200);

    agu_q.push_back(mk(16'h0010, 1'b0, 32'h8899_AABB, 2'd2, 1'b0, 4'h0));
    agu_q.push_back(mk(16'h0010, 1'b1, 32'h0, 2'd2, 1'b0, 4'h5));
    agu_q.push_back(mk(16'h0010, 1'b0, 32'h80FF_FFFF, 2'd2, 1'b0, 4'h0));
    agu_q.push_back(mk(16'h0013, 1'b1, 32'h0, 2'd0, 1'b0, 4'h1));
    agu_q.push_back(mk(16'h0013, 1'b1, 32'h0, 2'd0, 1'b1, 4'h2));
    agu_q.push_back(mk(16'h0000, 1'b0, 32'hBEEF_1234, 2'd2, 1'b0, 4'h0));
    agu_q.push_back(mk(16'h0002, 1'b1, 32'h0, 2'd1, 1'b1, 4'h3));
    wait_idle(100);

    // Contention: both requesters valid, mixed read/write.
    agu_q.push_back(mk(16'h0020, 1'b1, 32'h0, 2'd2, 1'b0, 4'h6));
    agu_q.push_back(mk(16'h0024, 1'b0, 32'h1357_9BDF, 2'd2, 1'b0, 4'h7));
    ext_q.push_back(mk(16'h0028, 1'b0, 32'h2468_ACE0, 2'd2, 1'b0, 4'h0));
    ext_q.push_back(mk(16'h0024, 1'b1, 32'h0, 2'd1, 1'b0, 4'h0));
    wait_idle(100);

    // AGU backpressure fills the response buffer.
    bus.agu_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) agu_q.push_back(mk(16'(4 * i), 1'b1, 32'h0, 2'd2, 1'b0, 4'(8 + i)));
    tick(8);
    bus.agu_rsp_ready = 1'b1;
    wait_idle(100);

    // EXT-owned head blocks a later AGU response.
    bus.ext_rsp_ready = 1'b0;
    ext_q.push_back(mk(16'h0004, 1'b1, 32'h0, 2'd0, 1'b0, 4'h0));
    tick(1);
    agu_q.push_back(mk(16'h0008, 1'b1, 32'h0, 2'd2, 1'b0, 4'hC));
    tick(6);
    bus.ext_rsp_ready = 1'b1;
    wait_idle(100);

    // Reset with two buffered responses; AGU must win the first grant after.
    bus.agu_rsp_ready = 1'b0;
    bus.ext_rsp_ready = 1'b0;
    ext_q.push_back(mk(16'h000C, 1'b1, 32'h0, 2'd2, 1'b0, 4'h0));
    tick(1);
    agu_q.push_back(mk(16'h0010, 1'b1, 32'h0, 2'd2, 1'b0, 4'hD));
    tick(5);
    rst = 1'b1;
    bus.agu_rsp_ready = 1'b1;
    bus.ext_rsp_ready = 1'b1;
    tick(1);
    rst = 1'b0;
    ext_q.push_back(mk(16'h0014, 1'b1, 32'h0, 2'd2, 1'b0, 4'h0));
    agu_q.push_back(mk(16'h0018, 1'b1, 32'h0, 2'd2, 1'b0, 4'hE));
    wait_idle(100);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && agu_q.size() < 3) agu_q.push_back(rand_cmd());
      if ($urandom_range(0, 2) == 0 && ext_q.size() < 3) ext_q.push_back(rand_cmd());
      bus.agu_rsp_ready = ($urandom_range(0, 3) != 0);
      bus.ext_rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    bus.agu_rsp_ready = 1'b1;
    bus.ext_rsp_ready = 1'b1;
    wait_idle(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_dtcm_arb.md
LSU_DTCM_ARB -- requirements
Module: lsu_dtcm_arb

Interface
REQ-001 Parameter: RSP_DEPTH, 2, number of response-buffer entries (legal values 2 and 4).
REQ-002 Widths XLEN, DTCM_ADDR_WIDTH and ITAG_WIDTH SHALL come from the shared defines.
REQ-003 Port: clk, in, 1, single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst, in, 1, reset, synchronous and active-high.
REQ-005 Port: agu_cmd_valid/agu_cmd_ready, in/out, 1/1, AGU command handshake.
REQ-006 Port: agu_cmd_addr, in, DTCM_ADDR_WIDTH, AGU command byte address.
REQ-007 Port: agu_cmd_read, in, 1, AGU read when 1, write when 0.
REQ-008 Port: agu_cmd_wdata, in, XLEN, AGU write data.
REQ-009 Port: agu_cmd_wmask, in, XLEN/8, AGU byte write mask.
REQ-010 Port: agu_cmd_size, in, 2, AGU access size (00 byte, 01 half, 10 word).
REQ-011 Port: agu_cmd_usign, in, 1, AGU unsigned load.
REQ-012 Port: agu_cmd_itag, in, ITAG_WIDTH, AGU instruction tag.
REQ-013 Port: ext_cmd_*, in/out, same set and widths as agu_cmd_* minus itag, second requester (debug/external).
REQ-014 Port: agu_rsp_valid/agu_rsp_ready, out/in, 1/1, AGU response handshake.
REQ-015 Port: agu_rsp_rdata, out, XLEN, AGU load result, already extended.
REQ-016 Port: agu_rsp_itag, out, ITAG_WIDTH, tag of the responding AGU command.
REQ-017 Port: ext_rsp_valid/ext_rsp_ready, out/in, 1/1, external response handshake.
REQ-018 Port: ext_rsp_rdata, out, XLEN, external load result, already extended.
REQ-019 Port: ram_cs, out, 1, DTCM chip select.
REQ-020 Port: ram_we, out, 1, DTCM write enable.
REQ-021 Port: ram_addr, out, DTCM_ADDR_WIDTH-2, DTCM word address.
REQ-022 Port: ram_wem, out, XLEN/8, DTCM byte write-enable mask.
REQ-023 Port: ram_din, out, XLEN, DTCM write data.
REQ-024 Port: ram_dout, in, XLEN, DTCM read data, valid exactly 1 cycle after ram_cs.

Function
REQ-025 The block SHALL issue at most one DTCM access per cycle.
REQ-026 An access SHALL issue only when (buffered entries + in-flight access) < RSP_DEPTH.
REQ-027 Arbitration SHALL be round-robin using a 1-bit last-grant pointer: with both requesters valid, the one not granted last wins; a single valid requester always wins.
REQ-028 x_cmd_ready SHALL be 1 only in the cycle requester x is granted; ram_cs SHALL equal the grant, with ram_we = ~read, ram_addr = addr[DTCM_ADDR_WIDTH-1:2], and ram_wem, ram_din copied from the winner.
REQ-029 Each issued command SHALL record metadata in an in-flight register: source, read, size, usign, addr[1:0], itag.
REQ-030 One cycle after issue, the in-flight metadata and ram_dout SHALL be written into the response FIFO (depth RSP_DEPTH, ordered).
REQ-031 Response data for loads: byte = ram_dout byte addr[1:0]; half = ram_dout half addr[1]; word = ram_dout as-is; then zero-extended when usign=1, sign-extended otherwise.
REQ-032 Response data for stores SHALL be 0.
REQ-033 The FIFO head SHALL drive x_rsp_valid only for its recorded source; it pops on x_rsp_valid & x_rsp_ready.
REQ-034 A head blocked by its owner SHALL stall the other source's responses; responses SHALL remain in order.
REQ-035 Fill and pop in the same cycle SHALL leave the FIFO count unchanged; read and write pointers SHALL wrap modulo RSP_DEPTH.
REQ-036 With the FIFO full, no grant SHALL occur; without backpressure, 1 access/cycle SHALL be sustained.
REQ-037 Latency SHALL be 2 cycles from the grant to the earliest response valid.

Reset
REQ-038 While rst=1: all cmd_ready, rsp_valid and ram_cs/ram_we outputs SHALL be 0.
REQ-039 While rst=1: FIFO pointers and count SHALL be 0, the in-flight valid bit SHALL be 0, and the RR pointer SHALL be 1 so that the AGU wins first.
REQ-040 Reset asserted mid-operation SHALL discard in-flight and buffered responses; no response SHALL appear after reset.
REQ-041 Data/metadata storage SHALL have no reset.

Structure
REQ-042 Size encodings and RSP_DEPTH default SHALL reside in the shared defines file.
REQ-043 The response FIFO SHALL be one sub-module, lsu_rsp_fifo, parameterized by width and depth.

Verification
REQ-044 AGU-only lw at 0x10, ram_dout=0x8899AABB -> agu_rsp_rdata=0x8899AABB two cycles after grant, itag echoed.
REQ-045 lb addr=0x13 usign=0, dout=0x80FFFFFF -> 0xFFFFFF80; same with usign=1 -> 0x00000080; lhu addr=0x2, dout=0xBEEF1234 -> 0x0000BEEF.
REQ-046 Both requesters valid for 4 cycles -> grants AGU, EXT, AGU, EXT; ram_we follows each winner's read bit.
REQ-047 agu_rsp_ready=0 with RSP_DEPTH=2 -> exactly 2 grants, then both cmd_ready held 0 until ready returns; responses in issue order.
REQ-048 Head owned by EXT with ext_rsp_ready=0 and the next entry owned by AGU -> agu_rsp_valid stays 0 until EXT pops.
REQ-049 rst pulsed while 2 responses are buffered -> rsp_valid=0 the next cycle, and the next grant goes to the AGU.
